// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Purpose  : Machine-mode trap sequencer. Picks one trap source in IDLE
//            (exception > MRET > interrupt), latches its kind, cause and PC,
//            stalls the pipeline until it drains, emits one commit strobe to
//            the CSR block, then hands a redirect target to fetch.
// Ports    : clk, reset             - clock, async active-high reset
//            mip, mie, MIE          - interrupt pending/enable/global enable
//            mtvec, mepc            - trap vector and return address
//            exc_valid/code/pc      - synchronous exception request
//            mret_valid, int_pc     - MRET retiring, PC of next instruction
//            flush_req, drain_ack   - pipeline stall/flush handshake
//            int/exp/ret_action,
//            hw_int, int_code,
//            trap_pc                - commit strobes and context to CSRs
//            redirect_valid/pc/ready- fetch redirect handshake
// Revision : 1.0 - initial release
// ============================================================================
module trap_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mip,
  input  logic [31:0] mie,
  input  logic        MIE,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        mret_valid,
  input  logic [31:0] int_pc,
  output logic        flush_req,
  input  logic        drain_ack,
  output logic        int_action,
  output logic        exp_action,
  output logic        ret_action,
  output logic        hw_int,
  output logic [4:0]  int_code,
  output logic [31:0] trap_pc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_EXC  = 2'd1,
    KIND_RET  = 2'd2,
    KIND_INT  = 2'd3
  } kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  // Only the external (11), software (3) and timer (7) lines are serviced.
  logic        irq_ext, irq_sw, irq_tmr, irq_pending;
  logic [4:0]  irq_code;
  logic        irq_still_pending;
  logic [31:0] vec_base, vec_offset;

  assign irq_ext     = mip[11] & mie[11];
  assign irq_sw      = mip[3]  & mie[3];
  assign irq_tmr     = mip[7]  & mie[7];
  assign irq_pending = MIE & (irq_ext | irq_sw | irq_tmr);

  always_comb begin
    irq_code = 5'd7;
    if (irq_ext) begin
      irq_code = 5'd11;
    end else if (irq_sw) begin
      irq_code = 5'd3;
    end
  end

  // The latched cause is the bit index, so it selects the line to re-check.
  assign irq_still_pending = MIE & mip[code_q] & mie[code_q];

  assign vec_base   = {mtvec[31:2], 2'b00};
  assign vec_offset = {25'd0, code_q, 2'b00};

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    code_d        = code_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          kind_d  = KIND_EXC;
          code_d  = exc_code;
          pc_d    = exc_pc;
          state_d = ST_DRAIN;
        end else if (mret_valid) begin
          kind_d  = KIND_RET;
          code_d  = 5'd0;
          pc_d    = 32'd0;
          state_d = ST_DRAIN;
        end else if (irq_pending) begin
          kind_d  = KIND_INT;
          code_d  = irq_code;
          pc_d    = int_pc;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A withdrawn interrupt is dropped even if the drain completes now.
        if ((kind_q == KIND_INT) && !irq_still_pending) begin
          state_d = ST_IDLE;
        end else if (drain_ack) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (kind_q == KIND_RET) begin
          redirect_pc_d = mepc;
        end else if ((kind_q == KIND_INT) && (mtvec[1:0] == 2'b01)) begin
          redirect_pc_d = vec_base + vec_offset;
        end else begin
          redirect_pc_d = vec_base;
        end
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      kind_q        <= KIND_NONE;
      code_q        <= 5'd0;
      pc_q          <= 32'd0;
      redirect_pc_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      code_q        <= code_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  logic in_commit;
  assign in_commit      = (state_q == ST_COMMIT);
  assign flush_req      = (state_q != ST_IDLE);
  assign int_action     = in_commit & (kind_q == KIND_INT);
  assign exp_action     = in_commit & (kind_q == KIND_EXC);
  assign ret_action     = in_commit & (kind_q == KIND_RET);
  assign hw_int         = int_action;
  assign int_code       = in_commit ? code_q : 5'd0;
  assign trap_pc        = in_commit ? pc_q : 32'd0;
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign redirect_pc    = redirect_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_ctrl
// Purpose  : Directed bench for trap_ctrl. Each trap request pushes its
//            expected commit/redirect record to a queue; the record is popped
//            and compared when the DUT raises its commit strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mip = '0, mie = '0, mtvec = '0, mepc = '0, exc_pc = '0, int_pc = '0;
  logic        MIE = 1'b0, exc_valid = 1'b0, mret_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic        drain_ack = 1'b0, redirect_ready = 1'b0;
  logic        flush_req, int_action, exp_action, ret_action, hw_int, redirect_valid;
  logic [4:0]  int_code;
  logic [31:0] trap_pc, redirect_pc;

  trap_ctrl dut (
    .clk(clk), .reset(reset), .mip(mip), .mie(mie), .MIE(MIE),
    .mtvec(mtvec), .mepc(mepc), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .mret_valid(mret_valid), .int_pc(int_pc),
    .flush_req(flush_req), .drain_ack(drain_ack), .int_action(int_action),
    .exp_action(exp_action), .ret_action(ret_action), .hw_int(hw_int),
    .int_code(int_code), .trap_pc(trap_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  strobes;   // {int, exp, ret}
    logic        hw;
    logic        chk_ctx;   // compare int_code/trap_pc (not meaningful for MRET)
    logic [4:0]  code;
    logic [31:0] tpc;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic hw, input logic ctx,
                      input logic [4:0] code, input logic [31:0] tpc, input logic [31:0] rpc);
    exp_t e;
    e.strobes = st; e.hw = hw; e.chk_ctx = ctx; e.code = code; e.tpc = tpc; e.rpc = rpc;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] ctl_vec();
    return {26'd0, flush_req, int_action, exp_action, ret_action, hw_int, redirect_valid};
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, ctl_vec(), 32'd0);
    chk({tag, "_int_code"}, 32'(int_code), 32'd0);
    chk({tag, "_trap_pc"}, trap_pc, 32'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
  endtask

  // Called at the negedge after drain_ack was raised. Expects the commit
  // strobe on the very next negedge, then redirect, then return to IDLE.
  task automatic commit_and_redirect(input string tag, input int stall);
    exp_t e;
    int   idx = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (int_action | exp_action | ret_action) begin
        idx = i;
        break;
      end
    end
    chk({tag, "_commit_latency"}, 32'(idx), 32'd0);
    drain_ack = 1'b0; exc_valid = 1'b0; mret_valid = 1'b0;
    MIE = 1'b0; mip = '0; mie = '0;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s_scoreboard: observed=empty expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_strobes"}, 32'({int_action, exp_action, ret_action}), 32'(e.strobes));
    chk({tag, "_hw_int"}, 32'(hw_int), 32'(e.hw));
    if (e.chk_ctx) begin
      chk({tag, "_int_code"}, 32'(int_code), 32'(e.code));
      chk({tag, "_trap_pc"}, trap_pc, e.tpc);
    end
    @(negedge clk);
    chk({tag, "_strobe_pulse"}, 32'({int_action, exp_action, ret_action, hw_int}), 32'd0);
    chk({tag, "_redirect_valid"}, 32'(redirect_valid), 32'd1);
    chk({tag, "_redirect_pc"}, redirect_pc, e.rpc);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_stall_valid"}, 32'(redirect_valid), 32'd1);
      chk({tag, "_stall_pc"}, redirect_pc, e.rpc);
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    chk({tag, "_idle"}, 32'({flush_req, redirect_valid}), 32'd0);
  endtask

  // Second half of request entry: DRAIN must be visible one edge later.
  task automatic enter_drain(input string tag);
    @(negedge clk);
    chk({tag, "_flush"}, 32'(flush_req), 32'd1);
    exc_valid = 1'b0; mret_valid = 1'b0;
    drain_ack = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, async: outputs must clear with no clock edge.
    #1 reset = 1'b1;
    #1 check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Exception, mtvec mode bits ignored for exceptions.
    exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 32'h100; mtvec = 32'h801;
    push(3'b010, 1'b0, 1'b1, 5'd2, 32'h100, 32'h800);
    enter_drain("exc");
    commit_and_redirect("exc", 0);

    // Interrupt, vectored: 0x1000 + 11*4.
    @(negedge clk);
    MIE = 1'b1; mip = 32'h888; mie = 32'h888; mtvec = 32'h1001; int_pc = 32'h40;
    push(3'b100, 1'b1, 1'b1, 5'd11, 32'h40, 32'h102C);
    enter_drain("int11");
    commit_and_redirect("int11", 0);

    // Software beats timer; vectored.
    @(negedge clk);
    MIE = 1'b1; mip = 32'h088; mie = 32'h088; mtvec = 32'h1001; int_pc = 32'h44;
    push(3'b100, 1'b1, 1'b1, 5'd3, 32'h44, 32'h100C);
    enter_drain("int3");
    commit_and_redirect("int3", 0);

    // Timer only enabled among all-pending lines; vectored.
    @(negedge clk);
    MIE = 1'b1; mip = 32'hFFF; mie = 32'h080; mtvec = 32'h1001; int_pc = 32'h48;
    push(3'b100, 1'b1, 1'b1, 5'd7, 32'h48, 32'h101C);
    enter_drain("int7");
    commit_and_redirect("int7", 0);

    // mtvec mode 10 behaves as direct.
    @(negedge clk);
    MIE = 1'b1; mip = 32'h008; mie = 32'h008; mtvec = 32'h1002; int_pc = 32'h4C;
    push(3'b100, 1'b1, 1'b1, 5'd3, 32'h4C, 32'h1000);
    enter_drain("int_mode2");
    commit_and_redirect("int_mode2", 0);

    // No request: global disable, then only unserviced lines.
    @(negedge clk);
    MIE = 1'b0; mip = 32'h888; mie = 32'h888;
    @(negedge clk);
    chk("no_irq_mie0", 32'(flush_req), 32'd0);
    MIE = 1'b1; mip = 32'h777; mie = 32'h777;
    @(negedge clk);
    chk("no_irq_other_bits", 32'(flush_req), 32'd0);
    MIE = 1'b0; mip = '0; mie = '0;

    // Exception + MRET + interrupt together: exception wins.
    @(negedge clk);
    exc_valid = 1'b1; exc_code = 5'd5; exc_pc = 32'h300; mret_valid = 1'b1;
    MIE = 1'b1; mip = 32'h800; mie = 32'h800; mtvec = 32'h1001;
    push(3'b010, 1'b0, 1'b1, 5'd5, 32'h300, 32'h1000);
    enter_drain("prio");
    commit_and_redirect("prio", 0);

    // MRET returns to mepc.
    @(negedge clk);
    mret_valid = 1'b1; mepc = 32'h2000;
    push(3'b001, 1'b0, 1'b0, 5'd0, 32'h0, 32'h2000);
    enter_drain("mret");
    commit_and_redirect("mret", 0);

    // Interrupt withdrawn during DRAIN: abort, no strobe.
    @(negedge clk);
    MIE = 1'b1; mip = 32'h008; mie = 32'h008;
    @(negedge clk);
    chk("abort_flush", 32'(flush_req), 32'd1);
    mip = '0;
    @(negedge clk);
    chk("abort_idle", ctl_vec(), 32'd0);
    @(negedge clk);
    chk("abort_quiet", ctl_vec(), 32'd0);

    // Withdrawal and drain_ack on the same edge: abort wins.
    mip = 32'h080; mie = 32'h080;
    @(negedge clk);
    chk("abort_ack_flush", 32'(flush_req), 32'd1);
    mip = '0; drain_ack = 1'b1;
    @(negedge clk);
    drain_ack = 1'b0;
    chk("abort_ack_idle", ctl_vec(), 32'd0);
    @(negedge clk);
    chk("abort_ack_quiet", ctl_vec(), 32'd0);
    MIE = 1'b0; mie = '0;

    // DRAIN holds without drain_ack and ignores new requests; redirect stalls.
    @(negedge clk);
    exc_valid = 1'b1; exc_code = 5'd13; exc_pc = 32'hABC0; mtvec = 32'h4000_0000;
    push(3'b010, 1'b0, 1'b1, 5'd13, 32'hABC0, 32'h4000_0000);
    @(negedge clk);
    exc_valid = 1'b0; mret_valid = 1'b1; exc_code = 5'd1;
    @(negedge clk);
    chk("hold_drain", ctl_vec(), 32'h20);
    @(negedge clk);
    chk("hold_drain2", ctl_vec(), 32'h20);
    mret_valid = 1'b0; drain_ack = 1'b1;
    commit_and_redirect("stall", 3);

    // redirect_ready held high throughout has no effect before REDIRECT.
    @(negedge clk);
    redirect_ready = 1'b1;
    exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h80; mtvec = 32'h600;
    push(3'b010, 1'b0, 1'b1, 5'd0, 32'h80, 32'h600);
    enter_drain("early_rdy");
    redirect_ready = 1'b1;
    commit_and_redirect("early_rdy", 0);

    // Reset in COMMIT.
    @(negedge clk);
    exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h500; mtvec = 32'h900;
    @(negedge clk);
    exc_valid = 1'b0; drain_ack = 1'b1;
    @(negedge clk);
    drain_ack = 1'b0;
    chk("rst_commit_pre", 32'(exp_action), 32'd1);
    reset = 1'b1;
    #1 check_all_zero("rst_commit");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_commit_after", ctl_vec(), 32'd0);
    end

    // Reset in REDIRECT.
    exc_valid = 1'b1; exc_code = 5'd6; exc_pc = 32'h700; mtvec = 32'hA00;
    @(negedge clk);
    exc_valid = 1'b0; drain_ack = 1'b1;
    @(negedge clk);
    drain_ack = 1'b0;
    @(negedge clk);
    chk("rst_redir_pre", 32'(redirect_valid), 32'd1);
    reset = 1'b1;
    #1 check_all_zero("rst_redir");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_redir_after", ctl_vec(), 32'd0);
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have: clk  in  1  rising-edge clock.
REQ-003 SHALL have: reset  in  1  async active-high reset.
REQ-004 SHALL have: mip  in  32, mie  in  32, MIE  in  1  pending, enable and global-enable state from the CSR block.
REQ-005 SHALL have: mtvec  in  32, mepc  in  32  trap vector and return address from the CSR block.
REQ-006 SHALL have: exc_valid  in  1, exc_code  in  5, exc_pc  in  32  synchronous exception request, cause and faulting PC.
REQ-007 SHALL have: mret_valid  in  1  MRET retiring; int_pc  in  32  PC of the next unexecuted instruction.
REQ-008 SHALL have: flush_req  out  1  stall/flush request to the pipeline; drain_ack  in  1  pipeline drained.
REQ-009 SHALL have: int_action, exp_action, ret_action, hw_int  out  1 each; int_code  out  5; trap_pc  out  32  commit strobes, cause and PC to the CSR block.
REQ-010 SHALL have: redirect_valid  out  1, redirect_pc  out  32, redirect_ready  in  1  fetch-redirect handshake.

Function
REQ-011 SHALL implement states IDLE, DRAIN, COMMIT, REDIRECT; all outputs SHALL be registered or decoded from state and latched registers only.
REQ-012 IDLE priority SHALL be: exc_valid (kind EXC) > mret_valid (kind RET) > interrupt (kind INT); the winner's kind, code and PC SHALL be latched and the FSM SHALL move to DRAIN on the next edge.
REQ-013 Interrupt SHALL be pending when MIE=1 and (mip & mie) is non-zero in bits 11, 3 or 7.
REQ-014 Among pending interrupts, priority SHALL be bit 11 (code 11) > bit 3 (code 3) > bit 7 (code 7); all other bits SHALL be ignored.
REQ-015 Latched PC SHALL be exc_pc for EXC, int_pc for INT and don't-care for RET; latched code SHALL be exc_code for EXC and the bit index for INT.
REQ-016 flush_req SHALL be 1 in DRAIN, COMMIT and REDIRECT, and 0 in IDLE.
REQ-017 DRAIN SHALL hold until drain_ack=1, then go to COMMIT; new exc_valid, mret_valid or interrupts SHALL be ignored in DRAIN.
REQ-018 In DRAIN, if kind=INT and the latched interrupt is no longer pending before drain_ack, the FSM SHALL abort to IDLE with no strobe; EXC and RET SHALL never abort.
REQ-019 If abort and drain_ack occur in the same cycle, abort SHALL win.
REQ-020 COMMIT SHALL last exactly one cycle.
REQ-021 In COMMIT, exactly one strobe SHALL be 1: int_action for INT, exp_action for EXC, ret_action for RET.
REQ-022 In COMMIT, hw_int SHALL equal (kind==INT), and int_code and trap_pc SHALL carry the latched values; all SHALL be 0 outside COMMIT.
REQ-023 In COMMIT, redirect_pc SHALL be registered as follows, with base={mtvec[31:2],2'b00}:
- RET: mepc.
- EXC: base.
- INT with mtvec[1:0]=01: base + (code<<2), 32-bit wrap.
- INT with mtvec[1:0]=00, 10 or 11: base.
REQ-024 REDIRECT SHALL hold redirect_valid=1 with redirect_pc stable until redirect_ready=1, then go to IDLE on that edge.
REQ-025 redirect_valid SHALL be 0 outside REDIRECT.
REQ-026 Latency: a request seen in IDLE at edge N SHALL give flush_req=1 after N; drain_ack at edge M SHALL give a strobe after M and redirect_valid after M+1.
REQ-027 redirect_ready asserted early SHALL have no effect outside REDIRECT.

Reset
REQ-028 While reset=1, the state SHALL be IDLE and all outputs and latched registers SHALL be 0, taking effect immediately and asynchronously.
REQ-029 Reset in any state SHALL abandon the operation with no strobe.
REQ-030 After reset deasserts, the first request SHALL be evaluated on the next clock edge.

Verification
REQ-031 The bench SHALL check: exc_valid=1, exc_code=2, exc_pc=0x100, mtvec=0x801; drain_ack one cycle later -> exp_action pulse with int_code=2 and trap_pc=0x100, then redirect_pc=0x800.
REQ-032 The bench SHALL check: MIE=1, mip=mie=0x888, mtvec=0x1001, int_pc=0x40 -> int_action and hw_int with int_code=11 and trap_pc=0x40, then redirect_pc=0x102C.
REQ-033 The bench SHALL check: exc_valid, mret_valid and an interrupt in the same cycle -> only exp_action; mret_valid in IDLE with mepc=0x2000 -> ret_action, then redirect_pc=0x2000.
REQ-034 The bench SHALL check: INT latched, mip bit cleared during DRAIN before drain_ack -> return to IDLE, flush_req=0, no strobe.
REQ-035 The bench SHALL check: redirect_ready=0 for 3 cycles -> redirect_valid and redirect_pc stable; ready=1 -> IDLE on the next edge.
REQ-036 The bench SHALL check: reset asserted in COMMIT and in REDIRECT -> all outputs 0 immediately, with no strobe after release.
